// File: rtl/fc_fold_scheduler.sv
// Fold scheduler for a binarized FC layer: latches one activation vector, sweeps the weight-slice
// index over FOLD passes and collects the popcounts into a full result buffer.
// Optional `define FOLD_SCHED_THRESH_EN adds per-neuron threshold comparison (thresh in, out_bin out).
`timescale 1ns / 1ps

module fc_fold_scheduler #(
   parameter int unsigned DIM_IN     = 110,
   parameter int unsigned LOG_DIM_IN = 7,
   parameter int unsigned DIM_OUT    = 32,
   parameter int unsigned FOLD       = 4,
   parameter int unsigned FW         = (FOLD > 1) ? $clog2(FOLD) : 1
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [DIM_IN-1:0]                        in_vec,
   output logic [DIM_IN-1:0]                        mul_vec,
   output logic [FW-1:0]                            fold_idx,
   input  logic [(DIM_OUT/FOLD)*(LOG_DIM_IN+1)-1:0] pc_in,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [DIM_OUT*(LOG_DIM_IN+1)-1:0]        out_cnt,
`ifdef FOLD_SCHED_THRESH_EN
   input  logic [DIM_OUT*(LOG_DIM_IN+1)-1:0]        thresh,
   output logic [DIM_OUT-1:0]                       out_bin,
`endif
   output logic                                     busy
);

   localparam int unsigned CW  = LOG_DIM_IN + 1;
   localparam int unsigned NPF = DIM_OUT / FOLD;
   localparam int unsigned SW  = NPF * CW;

   if ((DIM_OUT % FOLD) != 0) begin : g_bad_fold
      $error("fc_fold_scheduler: DIM_OUT must be a multiple of FOLD");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                   state_q, state_d;
   logic [DIM_IN-1:0]        mul_vec_q, mul_vec_d;
   logic [FW-1:0]            fold_q, fold_d;
   logic [DIM_OUT*CW-1:0]    cnt_q, cnt_d;
`ifdef FOLD_SCHED_THRESH_EN
   logic [DIM_OUT-1:0]       bin_q, bin_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         mul_vec_q <= '0;
         fold_q    <= '0;
         cnt_q     <= '0;
`ifdef FOLD_SCHED_THRESH_EN
         bin_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         mul_vec_q <= mul_vec_d;
         fold_q    <= fold_d;
         cnt_q     <= cnt_d;
`ifdef FOLD_SCHED_THRESH_EN
         bin_q     <= bin_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      mul_vec_d = mul_vec_q;
      fold_d    = fold_q;
      cnt_d     = cnt_q;
`ifdef FOLD_SCHED_THRESH_EN
      bin_d     = bin_q;
`endif
      case (state_q)
         StIdle: begin
            if (in_valid) begin
               mul_vec_d = in_vec;
               fold_d    = '0;
               state_d   = StRun;
            end
         end
         StRun: begin
            // Only the slice selected by the current fold index is rewritten this pass.
            for (int f = 0; f < int'(FOLD); f++) begin
               if (fold_q == FW'(f)) begin
                  cnt_d[f*SW +: SW] = pc_in;
`ifdef FOLD_SCHED_THRESH_EN
                  for (int j = 0; j < int'(NPF); j++) begin
                     bin_d[f*NPF + j] = (pc_in[j*CW +: CW] >= thresh[(f*NPF + j)*CW +: CW]);
                  end
`endif
               end
            end
            if (fold_q == FW'(FOLD - 1)) begin
               fold_d  = '0;
               state_d = StDone;
            end else begin
               fold_d = fold_q + FW'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q == StRun) || (state_q == StDone);
   assign mul_vec   = mul_vec_q;
   assign fold_idx  = fold_q;
   assign out_cnt   = cnt_q;
`ifdef FOLD_SCHED_THRESH_EN
   assign out_bin   = bin_q;
`endif

endmodule

// File: tb/tb_fc_fold_scheduler.sv
// Directed bench for fc_fold_scheduler (default parameters: DIM_IN=110, DIM_OUT=32, FOLD=4).
// The popcount datapath is modelled as slot j of slice f returning base + 10*f + j.
`timescale 1ns / 1ps

module tb_fc_fold_scheduler;

   localparam int DIM_IN = 110;
   localparam int DIM_OUT = 32;
   localparam int FOLD = 4;
   localparam int CW = 8;
   localparam int NPF = DIM_OUT / FOLD;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    in_valid;
   logic                    in_ready;
   logic [DIM_IN-1:0]       in_vec;
   logic [DIM_IN-1:0]       mul_vec;
   logic [1:0]              fold_idx;
   logic [NPF*CW-1:0]       pc_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [DIM_OUT*CW-1:0]   out_cnt;
   logic                    busy;
`ifdef FOLD_SCHED_THRESH_EN
   logic [DIM_OUT*CW-1:0]   thresh;
   logic [DIM_OUT-1:0]      out_bin;
`endif

   int tests = 0;
   int fails = 0;
   int base = 0;
   logic thr_mode = 1'b0;

   logic [DIM_IN-1:0] ones;
   logic [DIM_IN-1:0] vec_a;
   logic [DIM_IN-1:0] vec_b;
   logic [DIM_OUT*CW-1:0] held;
   int acc_t[2];
   int n_acc;
   int n_res;
   logic prev_ready;
   logic got;

   always #5 clk = ~clk;

   fc_fold_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .mul_vec   (mul_vec),
      .fold_idx  (fold_idx),
      .pc_in     (pc_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cnt   (out_cnt),
`ifdef FOLD_SCHED_THRESH_EN
      .thresh    (thresh),
      .out_bin   (out_bin),
`endif
      .busy      (busy)
   );

   function automatic logic [7:0] thr_tbl(int k);
      case (k)
         0: return 8'd54;
         1: return 8'd55;
         2: return 8'd56;
         default: return 8'd110;
      endcase
   endfunction

   always_comb begin
      pc_in = '0;
      for (int j = 0; j < NPF; j++) begin
         if (thr_mode) pc_in[j*CW +: CW] = thr_tbl(j % 4);
         else pc_in[j*CW +: CW] = 8'(base + 10 * int'(fold_idx) + j);
      end
   end

   function automatic logic [DIM_OUT*CW-1:0] exp_cnt(int b);
      logic [DIM_OUT*CW-1:0] r;
      r = '0;
      for (int n = 0; n < DIM_OUT; n++) r[n*CW +: CW] = 8'(b + 10 * (n / NPF) + (n % NPF));
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for out_valid; a timeout counts as a failed comparison.
   task automatic wait_valid(input string tag);
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         step();
         if (out_valid) got = 1'b1;
      end
      chk(tag, 256'(got), 256'd1);
   endtask

   initial begin
      ones = '1;
      vec_a = {2'b10, {27{4'hA}}};
      vec_b = {2'b01, {27{4'h5}}};
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_vec = '0;
      out_ready = 1'b0;
`ifdef FOLD_SCHED_THRESH_EN
      thresh = {DIM_OUT{8'd55}};
`endif
      #12;
      chk("rst_in_ready", 256'(in_ready), 256'd1);
      chk("rst_out_valid", 256'(out_valid), 256'd0);
      chk("rst_busy", 256'(busy), 256'd0);
      chk("rst_out_cnt", 256'(out_cnt), 256'd0);
      chk("rst_mul_vec", 256'(mul_vec), 256'd0);
      chk("rst_fold_idx", 256'(fold_idx), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle with no input: nothing moves.
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_flags", 256'({in_ready, out_valid, busy, fold_idx}), 256'b10000);
      end
      chk("idle_out_cnt", 256'(out_cnt), 256'd0);

      // First vector: all ones, base 0.
      in_vec = ones;
      in_valid = 1'b1;
      base = 0;
      step();
      in_valid = 1'b0;
      chk("acc_busy", 256'({busy, in_ready}), 256'b10);
      chk("acc_mul_vec", 256'(mul_vec), 256'(ones));
      for (int k = 0; k < FOLD; k++) begin
         chk("run_fold_idx", 256'(fold_idx), 256'(k));
         chk("run_no_valid", 256'(out_valid), 256'd0);
         chk("run_mul_vec", 256'(mul_vec), 256'(ones));
         step();
      end
      chk("done_valid", 256'(out_valid), 256'd1);
      chk("done_fold_idx", 256'(fold_idx), 256'd0);
      chk("done_cnt", 256'(out_cnt), 256'(exp_cnt(0)));

      // Backpressure in DONE while in_valid toggles.
      held = exp_cnt(0);
      in_vec = vec_a;
      for (int i = 0; i < 7; i++) begin
         in_valid = i[0];
         step();
         chk("hold_flags", 256'({out_valid, in_ready}), 256'b10);
         chk("hold_cnt", 256'(out_cnt), 256'(held));
         chk("hold_mul_vec", 256'(mul_vec), 256'(ones));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("release_idle", 256'({out_valid, in_ready, busy}), 256'b010);

      // Reset in the middle of RUN.
      in_vec = vec_a;
      in_valid = 1'b1;
      base = 20;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("mid_fold_idx", 256'(fold_idx), 256'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_cnt", 256'(out_cnt), 256'd0);
      chk("mrst_mul_vec", 256'(mul_vec), 256'd0);
      chk("mrst_flags", 256'({in_ready, out_valid, busy, fold_idx}), 256'b10000);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mrst_no_valid", 256'(out_valid), 256'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_idle", 256'({out_valid, in_ready}), 256'b01);

      // Fresh vector after reset gives a full, correct result.
      in_vec = vec_b;
      in_valid = 1'b1;
      base = 40;
      step();
      in_valid = 1'b0;
      wait_valid("post_rst_timeout");
      chk("post_rst_cnt", 256'(out_cnt), 256'(exp_cnt(40)));
      chk("post_rst_mul_vec", 256'(mul_vec), 256'(vec_b));
      out_ready = 1'b1;
      step();

      // Back-to-back with in_valid and out_ready tied high.
      in_vec = vec_a;
      base = 50;
      in_valid = 1'b1;
      n_acc = 0;
      n_res = 0;
      prev_ready = in_ready;
      for (int i = 0; i < 20; i++) begin
         step();
         if (prev_ready && !in_ready && n_acc < 2) begin
            acc_t[n_acc] = i;
            n_acc++;
         end
         prev_ready = in_ready;
         if (out_valid) begin
            chk("b2b_cnt", 256'(out_cnt), 256'(exp_cnt(base)));
            if (n_res == 0) chk("b2b_mul_a", 256'(mul_vec), 256'(vec_a));
            n_res++;
            in_vec = vec_b;
            base = 70;
         end
      end
      in_valid = 1'b0;
      chk("b2b_n_acc", 256'(n_acc), 256'd2);
      if (n_acc == 2) chk("b2b_gap", 256'(acc_t[1] - acc_t[0]), 256'd6);
      chk("b2b_n_res", 256'(n_res >= 2), 256'd1);
      chk("b2b_mul_b", 256'(mul_vec), 256'(vec_b));
      out_ready = 1'b0;
      for (int i = 0; i < 8 && !in_ready; i++) begin
         out_ready = 1'b1;
         step();
      end
      out_ready = 1'b0;

`ifdef FOLD_SCHED_THRESH_EN
      thr_mode = 1'b1;
      in_vec = ones;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_valid("thr_timeout");
      chk("thr_out_bin", 256'(out_bin), 256'(32'hEEEE_EEEE));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
